// File: rtl/result_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module  : result_writeback_pkg
// Brief   : Shared widths, constants and FSM encoding for result_writeback.
// Revision: 1.0 - initial release
// ============================================================================
package result_writeback_pkg;

  localparam int c_DATA_W     = 16;
  localparam int c_PACK       = 8;
  localparam int c_WORD_W     = c_DATA_W * c_PACK;
  localparam int c_ADDR_W     = 32;
  localparam int c_WFIFO_D    = 4;
  localparam int c_CNT_W      = 32;

  // Op sequencing: collect, push partial words, empty the FIFOs, report.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/result_writeback_lane_packer.sv
`default_nettype none
// ============================================================================
// Module  : wb_lane_packer
// Brief   : Packs one engine port's results into full-width words and queues
//           them in a small FIFO; counts received results against the total.
// Revision: 1.0 - initial release
// ============================================================================
module wb_lane_packer
  import result_writeback_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int PACK    = c_PACK,
  parameter int WFIFO_D = c_WFIFO_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_run,
  input  logic                     i_flush,
  input  logic [c_CNT_W-1:0]       i_total,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_result,
  input  logic                     i_pop,
  output logic                     o_empty,
  output logic [DATA_W*PACK-1:0]   o_data,
  output logic [PACK-1:0]          o_mask,
  output logic                     o_rcv_done,
  output logic                     o_drop
);

  localparam int IDX_W  = $clog2(PACK);
  localparam int PTR_W  = $clog2(WFIFO_D);
  localparam int WORD_W = DATA_W * PACK;
  localparam logic [PTR_W:0] c_FULL_CNT = WFIFO_D[PTR_W:0];

  logic [PACK-1:0][DATA_W-1:0] r_lanes;
  logic [IDX_W-1:0]            r_idx;
  logic [c_CNT_W-1:0]          r_count;
  logic [c_CNT_W-1:0]          r_total;
  logic [PTR_W:0]              r_wptr;
  logic [PTR_W:0]              r_rptr;
  logic [WORD_W-1:0]           r_fifo_data [WFIFO_D];
  logic [PACK-1:0]             r_fifo_mask [WFIFO_D];

  logic                        w_accept;
  logic                        w_last;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_push_ok;
  logic [WORD_W-1:0]           w_word;
  logic [PACK-1:0]             w_mask;

  // Strobes only count in RUN and only up to the configured total.
  assign w_accept  = i_run && i_wr_en && (r_count < r_total);
  assign w_last    = w_accept && (r_idx == IDX_W'(PACK - 1));
  assign w_push    = w_last || (i_flush && (r_idx != '0));
  assign o_empty   = (r_wptr == r_rptr);
  assign w_full    = ((r_wptr - r_rptr) == c_FULL_CNT);
  assign w_pop     = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign o_drop    = w_push && !w_push_ok;
  assign o_rcv_done = (r_count == r_total);
  assign o_data    = r_fifo_data[r_rptr[PTR_W-1:0]];
  assign o_mask    = r_fifo_mask[r_rptr[PTR_W-1:0]];

  // Word being pushed: the top lane bypasses the lane register on a full word.
  always_comb begin
    w_word = r_lanes;
    w_mask = '0;
    if (w_last) begin
      w_word[WORD_W-1 -: DATA_W] = i_result;
    end
    for (int l = 0; l < PACK; l++) begin
      if (w_last || (l < int'(r_idx))) begin
        w_mask[l] = 1'b1;
      end
    end
  end

  // Packing index, lane register, received count and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lanes <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_total <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (i_start) begin
      r_lanes <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_total <= i_total;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_accept) begin
        r_count <= r_count + c_CNT_W'(1);
      end
      if (w_push) begin
        r_lanes <= '0;
      end else if (w_accept) begin
        r_lanes[r_idx] <= i_result;
      end
      if (w_last || i_flush) begin
        r_idx <= '0;
      end else if (w_accept) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_push_ok) begin
        r_wptr <= r_wptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo_data[r_wptr[PTR_W-1:0]] <= w_word;
      r_fifo_mask[r_wptr[PTR_W-1:0]] <= w_mask;
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_writeback.sv
`default_nettype none
// ============================================================================
// Module  : result_writeback
// Brief   : Packs conv/pool engine results from two ports into 128-bit words
//           and issues addressed DMA write requests; pulses done per op.
// Revision: 1.0 - initial release
// ============================================================================
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int PACK    = c_PACK,
  parameter int ADDR_W  = c_ADDR_W,
  parameter int WFIFO_D = c_WFIFO_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_p0_base_addr,
  input  logic [ADDR_W-1:0]      i_p1_base_addr,
  input  logic [c_CNT_W-1:0]     i_p0_total,
  input  logic [c_CNT_W-1:0]     i_p1_total,
  input  logic [DATA_W-1:0]      i_p0_result,
  input  logic                   i_p0_result_wr_en,
  input  logic [DATA_W-1:0]      i_p1_result,
  input  logic                   i_p1_result_wr_en,
  output logic                   o_wr_req,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic [DATA_W*PACK-1:0] o_wr_data,
  output logic [PACK-1:0]        o_wr_mask,
  input  logic                   i_wr_ack,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overflow
);

  localparam int WORD_W = DATA_W * PACK;
  localparam logic [ADDR_W-1:0] c_ADDR_STEP = ADDR_W'(WORD_W / 8);

  wb_state_t           r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic                r_wr_req;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [WORD_W-1:0]   r_wr_data;
  logic [PACK-1:0]     r_wr_mask;
  logic                r_pri_p1;
  logic [ADDR_W-1:0]   r_p0_ptr;
  logic [ADDR_W-1:0]   r_p1_ptr;

  logic                w_start;
  logic                w_run;
  logic                w_flush;
  logic                w_load;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_p0_empty;
  logic                w_p1_empty;
  logic [WORD_W-1:0]   w_p0_data;
  logic [WORD_W-1:0]   w_p1_data;
  logic [PACK-1:0]     w_p0_mask;
  logic [PACK-1:0]     w_p1_mask;
  logic                w_p0_rcv_done;
  logic                w_p1_rcv_done;
  logic                w_p0_drop;
  logic                w_p1_drop;

  assign w_start = i_start && (r_state == ST_IDLE);
  assign w_run   = (r_state == ST_RUN);
  assign w_flush = (r_state == ST_FLUSH);

  // Output register can take a new word when empty or when its word is accepted.
  assign w_load = !r_wr_req || i_wr_ack;
  assign w_gnt0 = w_load && !w_p0_empty && (w_p1_empty || !r_pri_p1);
  assign w_gnt1 = w_load && !w_p1_empty && !w_gnt0;

  wb_lane_packer #(
    .DATA_W  (DATA_W),
    .PACK    (PACK),
    .WFIFO_D (WFIFO_D)
  ) u_pack_p0 (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_run      (w_run),
    .i_flush    (w_flush),
    .i_total    (i_p0_total),
    .i_wr_en    (i_p0_result_wr_en),
    .i_result   (i_p0_result),
    .i_pop      (w_gnt0),
    .o_empty    (w_p0_empty),
    .o_data     (w_p0_data),
    .o_mask     (w_p0_mask),
    .o_rcv_done (w_p0_rcv_done),
    .o_drop     (w_p0_drop)
  );

  wb_lane_packer #(
    .DATA_W  (DATA_W),
    .PACK    (PACK),
    .WFIFO_D (WFIFO_D)
  ) u_pack_p1 (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_run      (w_run),
    .i_flush    (w_flush),
    .i_total    (i_p1_total),
    .i_wr_en    (i_p1_result_wr_en),
    .i_result   (i_p1_result),
    .i_pop      (w_gnt1),
    .o_empty    (w_p1_empty),
    .o_data     (w_p1_data),
    .o_mask     (w_p1_mask),
    .o_rcv_done (w_p1_rcv_done),
    .o_drop     (w_p1_drop)
  );

  // Op sequencer with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_p0_rcv_done && w_p1_rcv_done) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_p0_empty && w_p1_empty && !r_wr_req) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag and per-port write address pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_p0_ptr   <= '0;
      r_p1_ptr   <= '0;
    end else if (w_start) begin
      r_overflow <= 1'b0;
      r_p0_ptr   <= i_p0_base_addr;
      r_p1_ptr   <= i_p1_base_addr;
    end else begin
      if (w_p0_drop || w_p1_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_gnt0) begin
        r_p0_ptr <= r_p0_ptr + c_ADDR_STEP;
      end
      if (w_gnt1) begin
        r_p1_ptr <= r_p1_ptr + c_ADDR_STEP;
      end
    end
  end

  // Round-robin output register; contents held while a request is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_req  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_mask <= '0;
      r_pri_p1  <= 1'b0;
    end else begin
      if (w_load) begin
        if (w_gnt0) begin
          r_wr_req  <= 1'b1;
          r_wr_addr <= r_p0_ptr;
          r_wr_data <= w_p0_data;
          r_wr_mask <= w_p0_mask;
          r_pri_p1  <= 1'b1;
        end else if (w_gnt1) begin
          r_wr_req  <= 1'b1;
          r_wr_addr <= r_p1_ptr;
          r_wr_data <= w_p1_data;
          r_wr_mask <= w_p1_mask;
          r_pri_p1  <= 1'b0;
        end else begin
          r_wr_req  <= 1'b0;
        end
      end
      if (w_start) begin
        r_pri_p1 <= 1'b0;
      end
    end
  end

  assign o_wr_req   = r_wr_req;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_wr_mask  = r_wr_mask;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_result_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_result_writeback
// Brief   : Randomized self-checking bench for result_writeback with a
//           chunk-and-address reference model and per-port scoreboards.
// Revision: 1.0 - initial release
// ============================================================================
module tb_result_writeback;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [7:0]   mask;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [31:0]  i_p0_base_addr, i_p1_base_addr;
  logic [31:0]  i_p0_total, i_p1_total;
  logic [15:0]  i_p0_result, i_p1_result;
  logic         i_p0_result_wr_en, i_p1_result_wr_en;
  logic         o_wr_req;
  logic [31:0]  o_wr_addr;
  logic [127:0] o_wr_data;
  logic [7:0]   o_wr_mask;
  logic         i_wr_ack = 1'b0;
  logic         o_busy, o_done, o_overflow;

  always #5 clk = ~clk;

  result_writeback #(
    .DATA_W  (16),
    .PACK    (8),
    .ADDR_W  (32),
    .WFIFO_D (4)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_p0_base_addr    (i_p0_base_addr),
    .i_p1_base_addr    (i_p1_base_addr),
    .i_p0_total        (i_p0_total),
    .i_p1_total        (i_p1_total),
    .i_p0_result       (i_p0_result),
    .i_p0_result_wr_en (i_p0_result_wr_en),
    .i_p1_result       (i_p1_result),
    .i_p1_result_wr_en (i_p1_result_wr_en),
    .o_wr_req          (o_wr_req),
    .o_wr_addr         (o_wr_addr),
    .o_wr_data         (o_wr_data),
    .o_wr_mask         (o_wr_mask),
    .i_wr_ack          (i_wr_ack),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_overflow        (o_overflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model state
  logic [15:0] res0[$];
  logic [15:0] res1[$];
  wr_t         exp_q0[$];
  wr_t         exp_q1[$];

  int cyc = 0;
  int ack_mode = 0;        // 0: always ack, 1: random ack, 2: never ack
  int n_wr, first_port, first_req_cyc, done_cnt = 0, done_cyc, start_cyc, stb8_cyc;

  always @(posedge clk) cyc++;

  // Single driver for wr_ack
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       i_wr_ack = 1'b1;
      1:       i_wr_ack = ($urandom_range(0, 99) < 60);
      default: i_wr_ack = 1'b0;
    endcase
  end

  // Results of one port chopped into 8-lane words, one address per word.
  function automatic int model_port(int p, logic [31:0] base, int max_words);
    int  n;
    int  cnt;
    wr_t e;
    n   = (p == 0) ? res0.size() : res1.size();
    cnt = 0;
    for (int w = 0; w * 8 < n; w++) begin
      e.addr = base + 32'(w * 16);
      e.data = '0;
      e.mask = '0;
      for (int l = 0; l < 8; l++) begin
        if (w * 8 + l < n) begin
          e.data[l*16 +: 16] = (p == 0) ? res0[w*8+l] : res1[w*8+l];
          e.mask[l] = 1'b1;
        end
      end
      if (max_words < 0 || w < max_words) begin
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        cnt++;
      end
    end
    return cnt;
  endfunction

  // Monitor: scoreboard writes, stall stability, done pulses
  logic         p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
  logic [31:0]  p_addr;
  logic [127:0] p_data;
  logic [7:0]   p_mask;
  wr_t          mon_e;
  int           mon_port;

  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      if (p_req && !p_ack) begin
        chk("stall_hold_ctl", {o_wr_req, o_wr_mask, o_wr_addr}, {1'b1, p_mask, p_addr});
        chk("stall_hold_data", o_wr_data, p_data);
      end
      if (o_wr_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (o_wr_req && i_wr_ack) begin
        mon_port = o_wr_addr[29] ? 1 : 0;
        if (n_wr == 0) first_port = mon_port;
        n_wr++;
        if ((mon_port == 0 && exp_q0.size() == 0) || (mon_port == 1 && exp_q1.size() == 0)) begin
          chk("extra_write", {96'd0, o_wr_addr}, 128'd0);
        end else begin
          mon_e = (mon_port == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("wr_addr", o_wr_addr, mon_e.addr);
          chk("wr_data", o_wr_data, mon_e.data);
          chk("wr_mask", o_wr_mask, mon_e.mask);
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    p_req  = o_wr_req;
    p_ack  = i_wr_ack;
    p_rst  = rst;
    p_addr = o_wr_addr;
    p_data = o_wr_data;
    p_mask = o_wr_mask;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},  o_wr_req,   1'b0);
    chk({tag, "_addr"}, o_wr_addr,  32'd0);
    chk({tag, "_data"}, o_wr_data,  128'd0);
    chk({tag, "_mask"}, o_wr_mask,  8'd0);
    chk({tag, "_busy"}, o_busy,     1'b0);
    chk({tag, "_done"}, o_done,     1'b0);
    chk({tag, "_ovf"},  o_overflow, 1'b0);
  endtask

  // One op: build expectations, pulse start, stream results, await done.
  task automatic run_op(input int t0, input int t1, input bit pat, input int ack_md,
                        input int stb_pct, input int max_w0, input bit exp_ovf);
    int s0, s1, d0, nexp;
    logic [31:0] b0, b1;
    res0.delete(); res1.delete(); exp_q0.delete(); exp_q1.delete();
    for (int i = 0; i < t0; i++) res0.push_back(pat ? 16'(i + 1) : 16'($urandom));
    for (int i = 0; i < t1; i++) res1.push_back(pat ? 16'(256 + i + 1) : 16'($urandom));
    b0 = 32'h1000_0000 | (32'($urandom_range(0, 255)) << 4);
    b1 = 32'h2000_0000 | (32'($urandom_range(0, 255)) << 4);
    nexp = model_port(0, b0, max_w0) + model_port(1, b1, -1);
    n_wr = 0; first_port = -1; first_req_cyc = -1; stb8_cyc = -1;
    d0 = done_cnt;
    ack_mode = ack_md;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_p0_base_addr = b0; i_p1_base_addr = b1;
    i_p0_total = 32'(t0); i_p1_total = 32'(t1);
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1'b1);
    s0 = 0; s1 = 0;
    while (s0 < t0 || s1 < t1) begin
      i_p0_result_wr_en = 1'b0;
      i_p1_result_wr_en = 1'b0;
      if ($urandom_range(0, 99) < stb_pct) begin
        i_p0_result_wr_en = 1'b1;
        if (s0 < t0) begin
          i_p0_result = res0[s0];
          if (s0 == 7) stb8_cyc = cyc;
          s0++;
        end else i_p0_result = 16'hDEAD;
      end
      if ($urandom_range(0, 99) < stb_pct) begin
        i_p1_result_wr_en = 1'b1;
        if (s1 < t1) begin
          i_p1_result = res1[s1];
          s1++;
        end else i_p1_result = 16'hBEEF;
      end
      @(posedge clk); #1;
    end
    i_p0_result_wr_en = 1'b0;
    i_p1_result_wr_en = 1'b0;
    if (ack_md == 2) ack_mode = 0;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(posedge clk);
    #1;
    chk("done_pulse", 32'(done_cnt - d0), 32'd1);
    chk("busy_after_done", o_busy, 1'b0);
    chk("overflow", o_overflow, exp_ovf);
    chk("write_count", 32'(n_wr), 32'(nexp));
    chk("p0_all_written", 32'(exp_q0.size()), 32'd0);
    chk("p1_all_written", 32'(exp_q1.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0;
    i_p0_base_addr = '0; i_p1_base_addr = '0; i_p0_total = '0; i_p1_total = '0;
    i_p0_result = '0; i_p1_result = '0; i_p0_result_wr_en = 1'b0; i_p1_result_wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 16 sequential results on port 0, ack tied high
    run_op(16, 0, 1'b1, 0, 100, -1, 1'b0);
    chk("first_word_latency", 32'(first_req_cyc - stb8_cyc), 32'd2);

    // Partial last word
    run_op(11, 0, 1'b1, 0, 100, -1, 1'b0);

    // Both ports together: port 0 wins first
    run_op(8, 8, 1'b1, 0, 100, -1, 1'b0);
    chk("rr_first_port", 32'(first_port), 32'd0);

    // Stalled DMA: only FIFO depth + output register survive
    run_op(48, 0, 1'b0, 2, 100, 5, 1'b1);

    // Empty op: start sampled at the next edge, done three clocks after that
    run_op(0, 0, 1'b0, 0, 100, -1, 1'b0);
    chk("empty_done_latency", 32'(done_cyc - start_cyc), 32'd4);

    // Reset in the middle of RUN with a request outstanding
    ack_mode = 2;
    @(posedge clk); #1;
    i_start = 1'b1; i_p0_total = 32'd40; i_p1_total = 32'd0;
    i_p0_base_addr = 32'h1000_0000; i_p1_base_addr = 32'h2000_0000;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_p0_result_wr_en = 1'b1;
      i_p0_result = 16'(i);
      @(posedge clk); #1;
    end
    i_p0_result_wr_en = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", o_wr_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    ack_mode = 0;
    run_op(20, 13, 1'b0, 1, 70, -1, 1'b0);

    // Randomized ops
    for (int r = 0; r < 8; r++) begin
      run_op($urandom_range(0, 40), $urandom_range(0, 40), 1'b0, 1, 70, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
